bc1_encoder: RTL and testbench

//  Encodes 16 sequential RGB888 texels (one 4x4 tile, raster order) into one 64-bit BC1 (DXT1) block.

---
 rtl/bc1_encoder.sv | 160 ++++++++++++++++
 tb/tb_bc1_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bc1_encoder.sv
// bc1_encoder: packs a 4x4 RGB888 tile into a 64-bit BC1 block (bbox endpoints, SAD nearest palette index)
module bc1_encoder #(
   parameter bit ALPHA_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   input  logic [23:0] pixel_rgb,
   input  logic        pixel_transparent,
   output logic        block_valid,
   input  logic        block_ready,
   output logic [63:0] block_out
);
   localparam logic [1:0] S_COLLECT   = 2'd0;
   localparam logic [1:0] S_ENDPOINTS = 2'd1;
   localparam logic [1:0] S_INDEX     = 2'd2;
   localparam logic [1:0] S_OUTPUT    = 2'd3;

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic [23:0] r_rgb [16];
   logic [15:0] r_tr;
   logic [23:0] r_min, r_max;
   logic        r_any_t, r_any_o;
   logic [15:0] r_c0, r_c1;
   logic [23:0] r_pal [4];
   logic [31:0] r_idx;
   logic        r_bv;

   logic        w_tr_in, w_acc;
   logic [15:0] w_hi, w_lo, w_c0, w_c1;
   logic [23:0] w_e0, w_e1, w_col2, w_col3, w_px;
   logic [9:0]  w_d0, w_d1, w_d2, w_d3, w_m01, w_m012;
   logic [1:0]  w_b01, w_b012, w_best, w_idx;

   function automatic logic [23:0] expand(input logic [15:0] c);
      return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
   endfunction

   // half=1: (a+b)/2, half=0: (2a+b)/3, per channel with truncation
   function automatic logic [23:0] blend(input logic [23:0] a, input logic [23:0] b, input logic half);
      logic [23:0] res;
      logic [9:0]  s;
      res = '0;
      for (int k = 0; k < 3; k++) begin
         s = half ? ({2'b0, a[k*8 +: 8]} + {2'b0, b[k*8 +: 8]}) >> 1
                  : ({1'b0, a[k*8 +: 8], 1'b0} + {2'b0, b[k*8 +: 8]}) / 10'd3;
         res[k*8 +: 8] = s[7:0];
      end
      return res;
   endfunction

   function automatic logic [9:0] sad(input logic [23:0] a, input logic [23:0] b);
      logic [9:0] acc;
      acc = '0;
      for (int k = 0; k < 3; k++)
         acc = acc + {2'b0, (a[k*8 +: 8] > b[k*8 +: 8]) ? a[k*8 +: 8] - b[k*8 +: 8] : b[k*8 +: 8] - a[k*8 +: 8]};
      return acc;
   endfunction

   function automatic logic [23:0] cmin(input logic [23:0] a, input logic [23:0] b);
      logic [23:0] res;
      res = '0;
      for (int k = 0; k < 3; k++)
         res[k*8 +: 8] = (a[k*8 +: 8] < b[k*8 +: 8]) ? a[k*8 +: 8] : b[k*8 +: 8];
      return res;
   endfunction

   function automatic logic [23:0] cmax(input logic [23:0] a, input logic [23:0] b);
      logic [23:0] res;
      res = '0;
      for (int k = 0; k < 3; k++)
         res[k*8 +: 8] = (a[k*8 +: 8] > b[k*8 +: 8]) ? a[k*8 +: 8] : b[k*8 +: 8];
      return res;
   endfunction

   assign pixel_ready = (r_state == S_COLLECT);
   assign block_valid = r_bv;
   assign block_out   = {r_c0, r_c1, r_idx};
   assign w_tr_in     = ALPHA_EN & pixel_transparent;
   assign w_acc       = pixel_valid && pixel_ready;

   // Transparent tiles swap endpoints so c0<=c1 selects the 3-colour decode mode
   assign w_hi   = {r_max[23:19], r_max[15:10], r_max[7:3]};
   assign w_lo   = {r_min[23:19], r_min[15:10], r_min[7:3]};
   assign w_c0   = !r_any_o ? 16'h0000 : r_any_t ? w_lo : w_hi;
   assign w_c1   = !r_any_o ? 16'h0000 : r_any_t ? w_hi : w_lo;
   assign w_e0   = expand(w_c0);
   assign w_e1   = expand(w_c1);
   assign w_col2 = blend(w_e0, w_e1, r_any_t);
   assign w_col3 = blend(w_e1, w_e0, 1'b0);

   assign w_px   = r_rgb[r_cnt];
   assign w_d0   = sad(w_px, r_pal[0]);
   assign w_d1   = sad(w_px, r_pal[1]);
   assign w_d2   = sad(w_px, r_pal[2]);
   assign w_d3   = sad(w_px, r_pal[3]);
   // Strict less-than keeps the lowest index on ties
   assign w_b01  = (w_d1 < w_d0) ? 2'd1 : 2'd0;
   assign w_m01  = (w_d1 < w_d0) ? w_d1 : w_d0;
   assign w_b012 = (w_d2 < w_m01) ? 2'd2 : w_b01;
   assign w_m012 = (w_d2 < w_m01) ? w_d2 : w_m01;
   assign w_best = (!r_any_t && w_d3 < w_m012) ? 2'd3 : w_b012;
   assign w_idx  = (r_any_t && r_tr[r_cnt]) ? 2'd3 : w_best;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_COLLECT;
         r_cnt   <= '0;
         for (int i = 0; i < 16; i++) r_rgb[i] <= '0;
         for (int i = 0; i < 4; i++) r_pal[i] <= '0;
         r_tr    <= '0;
         r_min   <= 24'hFFFFFF;
         r_max   <= '0;
         r_any_t <= 1'b0;
         r_any_o <= 1'b0;
         r_c0    <= '0;
         r_c1    <= '0;
         r_idx   <= '0;
         r_bv    <= 1'b0;
      end else begin
         case (r_state)
            S_COLLECT: if (w_acc) begin
               r_rgb[r_cnt] <= pixel_rgb;
               r_tr[r_cnt]  <= w_tr_in;
               r_min        <= w_tr_in ? r_min : cmin(r_min, pixel_rgb);
               r_max        <= w_tr_in ? r_max : cmax(r_max, pixel_rgb);
               r_any_t      <= r_any_t | w_tr_in;
               r_any_o      <= r_any_o | !w_tr_in;
               r_cnt        <= r_cnt + 4'd1;
               r_state      <= (r_cnt == 4'd15) ? S_ENDPOINTS : S_COLLECT;
            end
            S_ENDPOINTS: begin
               r_c0     <= w_c0;
               r_c1     <= w_c1;
               r_pal[0] <= w_e0;
               r_pal[1] <= w_e1;
               r_pal[2] <= w_col2;
               r_pal[3] <= w_col3;
               r_state  <= S_INDEX;
            end
            S_INDEX: begin
               r_idx[{r_cnt, 1'b0} +: 2] <= w_idx;
               r_cnt   <= r_cnt + 4'd1;
               r_state <= (r_cnt == 4'd15) ? S_OUTPUT : S_INDEX;
               r_bv    <= (r_cnt == 4'd15);
            end
            S_OUTPUT: if (block_ready) begin
               r_bv    <= 1'b0;
               r_state <= S_COLLECT;
               r_min   <= 24'hFFFFFF;
               r_max   <= '0;
               r_any_t <= 1'b0;
               r_any_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bc1_encoder.sv
// tb_bc1_encoder: directed BC1 tiles with hand-computed blocks; a second instance covers ALPHA_EN=0
module tb_bc1_encoder;
   logic        clk = 1'b0;
   logic        rst, pixel_valid, pixel_transparent, block_ready;
   logic [23:0] pixel_rgb;
   logic        pixel_ready, block_valid, rdy_na, bv_na;
   logic [63:0] block_out, out_na;
   logic [23:0] t_rgb [16];
   logic        t_tr [16];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   bc1_encoder #(.ALPHA_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .pixel_rgb(pixel_rgb), .pixel_transparent(pixel_transparent),
      .block_valid(block_valid), .block_ready(block_ready), .block_out(block_out));

   bc1_encoder #(.ALPHA_EN(1'b0)) u_dut_na (
      .clk(clk), .rst(rst), .pixel_valid(pixel_valid), .pixel_ready(rdy_na),
      .pixel_rgb(pixel_rgb), .pixel_transparent(pixel_transparent),
      .block_valid(bv_na), .block_ready(block_ready), .block_out(out_na));

   task automatic load(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                       input logic [23:0] d, input logic [3:0] trm);
      for (int i = 0; i < 16; i++) begin
         t_rgb[i] = (i % 4 == 0) ? a : (i % 4 == 1) ? b : (i % 4 == 2) ? c : d;
         t_tr[i]  = trm[i % 4];
      end
   endtask

   task automatic push(input int gap, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pixel_valid = 1'b0;
         repeat (gap) @(negedge clk);
         pixel_valid       = 1'b1;
         pixel_rgb         = t_rgb[i];
         pixel_transparent = t_tr[i];
         @(posedge clk);
      end
      #1 pixel_valid = 1'b0;
   endtask

   task automatic wait_blk(output int lat);
      lat = 0;
      while (!block_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      block_ready = 1'b1;
      @(posedge clk);
      #1 block_ready = 1'b0;
   endtask

   task automatic do_tile(input int gap, output int lat, output logic [63:0] got, output logic [63:0] got_na);
      push(gap, 16);
      wait_blk(lat);
      got    = block_out;
      got_na = out_na;
      handshake();
   endtask

   task automatic test_reset();
      rst = 1'b1; pixel_valid = 1'b0; pixel_rgb = '0; pixel_transparent = 1'b0; block_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_vec++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", pixel_ready); end
      n_vec++; if (block_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", block_valid); end
      n_vec++; if (block_out !== 64'h0) begin n_err++; $display("FAIL reset_out got %h want 0", block_out); end
   endtask

   task automatic test_flat();
      int lat; logic [63:0] got, got_na;
      load(24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 4'b0000);
      do_tile(0, lat, got, got_na);
      n_vec++; if (lat < 17 || lat > 18) begin n_err++; $display("FAIL flat_latency got %0d want 17..18", lat); end
      n_vec++; if (got !== 64'hF800_F800_0000_0000) begin n_err++; $display("FAIL flat_block got %h want F800F80000000000", got); end
      n_vec++; if (block_valid !== 1'b0 || pixel_ready !== 1'b1) begin n_err++; $display("FAIL flat_release got v=%b r=%b want v=0 r=1", block_valid, pixel_ready); end
   endtask

   task automatic test_checker();
      int lat; logic [63:0] got, got_na;
      load(24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 4'b0000);
      do_tile(0, lat, got, got_na);
      n_vec++; if (got !== 64'hFFFF_0000_1111_1111) begin n_err++; $display("FAIL checker_block got %h want FFFF000011111111", got); end
   endtask

   task automatic test_transparent();
      int lat; logic [63:0] got, got_na;
      load(24'h0, 24'h0, 24'h0, 24'h0, 4'b1111);
      do_tile(0, lat, got, got_na);
      n_vec++; if (got !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL alltrans_block got %h want 00000000FFFFFFFF", got); end
      n_vec++; if (got_na !== 64'h0) begin n_err++; $display("FAIL alltrans_noalpha got %h want 0", got_na); end
   endtask

   task automatic test_punch();
      int lat; logic [63:0] got, got_na;
      load(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 4'b0000);
      t_tr[0] = 1'b1; t_rgb[0] = 24'h0;
      do_tile(0, lat, got, got_na);
      n_vec++; if (got !== 64'hFFFF_FFFF_0000_0003) begin n_err++; $display("FAIL punch_block got %h want FFFFFFFF00000003", got); end
      n_vec++; if (got_na !== 64'hFFFF_0000_0000_0001) begin n_err++; $display("FAIL punch_noalpha got %h want FFFF000000000001", got_na); end
   endtask

   task automatic test_palette_opaque();
      int lat; logic [63:0] got, got_na;
      load(24'h000000, 24'hFFFFFF, 24'hAAAAAA, 24'h555555, 4'b0000);
      do_tile(0, lat, got, got_na);
      n_vec++; if (got !== 64'hFFFF_0000_E1E1_E1E1) begin n_err++; $display("FAIL pal4_block got %h want FFFF0000E1E1E1E1", got); end
   endtask

   task automatic test_palette_alpha();
      int lat; logic [63:0] got, got_na;
      load(24'h000000, 24'h000000, 24'hFFFFFF, 24'h7F7F7F, 4'b0001);
      t_rgb[15] = 24'hAAAAAA;
      do_tile(0, lat, got, got_na);
      n_vec++; if (got !== 64'h0000_FFFF_9393_9393) begin n_err++; $display("FAIL pal3_block got %h want 0000FFFF93939393", got); end
   endtask

   task automatic test_stall();
      int lat;
      load(24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 4'b0000);
      push(2, 16);
      wait_blk(lat);
      n_vec++; if (lat < 17 || lat > 18) begin n_err++; $display("FAIL stall_latency got %0d want 17..18", lat); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_vec++;
         if (block_valid !== 1'b1 || block_out !== 64'hFFFF_0000_1111_1111 || pixel_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold cyc %0d got v=%b r=%b out=%h want v=1 r=0 out=FFFF000011111111", c, block_valid, pixel_ready, block_out);
         end
      end
      handshake();
      n_vec++; if (block_valid !== 1'b0 || pixel_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got v=%b r=%b want v=0 r=1", block_valid, pixel_ready); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [63:0] got, got_na;
      load(24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 4'b0000);
      push(0, 8);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (pixel_ready !== 1'b1 || block_valid !== 1'b0 || block_out !== 64'h0) begin
         n_err++;
         $display("FAIL midrst_state got r=%b v=%b out=%h want r=1 v=0 out=0", pixel_ready, block_valid, block_out);
      end
      do_tile(0, lat, got, got_na);
      n_vec++; if (got !== 64'hF800_F800_0000_0000) begin n_err++; $display("FAIL midrst_block got %h want F800F80000000000", got); end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_checker();
      test_transparent();
      test_punch();
      test_palette_opaque();
      test_palette_alpha();
      test_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
